// File: rtl/fifo_wptr_gen.sv
// Write-side pointer and flag generator for the dual-clock FIFO.
// Keeps the binary write count and its Gray image, and derives full, almost-full, level and overflow.
module fifo_wptr_gen #(
    parameter int ADDR_SIZE = 3,
    parameter int PTR_SIZE  = ADDR_SIZE + 1,
    parameter int AF_THRESH = (1 << ADDR_SIZE) - 2
) (
    input  logic                 w_clk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [PTR_SIZE-1:0]  wq2_rptr,
    input  logic                 w_ovf_clr,
    output logic [PTR_SIZE-1:0]  wptr,
    output logic [ADDR_SIZE-1:0] w_addr,
    output logic                 w_en,
    output logic                 w_full,
    output logic                 w_almost_full,
    output logic [PTR_SIZE-1:0]  w_level,
    output logic                 w_overflow
);

    // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
    localparam logic [PTR_SIZE-1:0] FULL_FLIP = {2'b11, {(PTR_SIZE-2){1'b0}}};
    localparam logic [PTR_SIZE-1:0] AF_LIMIT  = PTR_SIZE'(AF_THRESH);

    logic [PTR_SIZE-1:0]  r_wbin;
    logic [PTR_SIZE-1:0]  r_wptr;
    logic [ADDR_SIZE-1:0] r_addr;
    logic                 r_full;
    logic                 r_afull;
    logic [PTR_SIZE-1:0]  r_level;
    logic                 r_ovf;

    logic                 w_accept;
    logic [PTR_SIZE-1:0]  w_wbin_next;
    logic [PTR_SIZE-1:0]  w_wgray_next;
    logic [PTR_SIZE-1:0]  w_rbin;
    logic [PTR_SIZE-1:0]  w_level_next;

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi < PTR_SIZE; gi++) begin : g_gray2bin
        assign w_rbin[gi] = ^wq2_rptr[PTR_SIZE-1:gi];
    end

    assign w_accept     = winc & ~r_full;
    assign w_wbin_next  = r_wbin + PTR_SIZE'(w_accept);
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_addr  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wptr  <= w_wgray_next;
            r_addr  <= w_wbin_next[ADDR_SIZE-1:0];
            r_full  <= (w_wgray_next == (wq2_rptr ^ FULL_FLIP));
            r_afull <= (w_level_next >= AF_LIMIT);
            r_level <= w_level_next;
            if (winc & r_full) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign wptr          = r_wptr;
    assign w_addr        = r_addr;
    assign w_en          = w_accept;
    assign w_full        = r_full;
    assign w_almost_full = r_afull;
    assign w_level       = r_level;
    assign w_overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_gen.sv
// Bench for fifo_wptr_gen: directed vector table plus randomized traffic checked against a count-based model.
// Three instances cover depths 8, 4 and 64.
module tb_fifo_wptr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, winc0, clr0, wen0, full0, af0, ovf0;
    logic [3:0] rptr0, wptr0, lvl0;
    logic [2:0] addr0;

    logic       rst1, winc1, clr1, wen1, full1, af1, ovf1;
    logic [2:0] rptr1, wptr1, lvl1;
    logic [1:0] addr1;

    logic       rst2, winc2, clr2, wen2, full2, af2, ovf2;
    logic [6:0] rptr2, wptr2, lvl2;
    logic [5:0] addr2;

    fifo_wptr_gen #(.ADDR_SIZE(3), .AF_THRESH(6)) u_a3 (
        .w_clk(clk), .wrst(rst0), .winc(winc0), .wq2_rptr(rptr0), .w_ovf_clr(clr0),
        .wptr(wptr0), .w_addr(addr0), .w_en(wen0), .w_full(full0),
        .w_almost_full(af0), .w_level(lvl0), .w_overflow(ovf0));

    fifo_wptr_gen #(.ADDR_SIZE(2), .AF_THRESH(4)) u_a2 (
        .w_clk(clk), .wrst(rst1), .winc(winc1), .wq2_rptr(rptr1), .w_ovf_clr(clr1),
        .wptr(wptr1), .w_addr(addr1), .w_en(wen1), .w_full(full1),
        .w_almost_full(af1), .w_level(lvl1), .w_overflow(ovf1));

    fifo_wptr_gen #(.ADDR_SIZE(6)) u_a6 (
        .w_clk(clk), .wrst(rst2), .winc(winc2), .wq2_rptr(rptr2), .w_ovf_clr(clr2),
        .wptr(wptr2), .w_addr(addr2), .w_en(wen2), .w_full(full2),
        .w_almost_full(af2), .w_level(lvl2), .w_overflow(ovf2));

    // Model state: number of accepted writes since reset plus the registered flags.
    typedef struct packed {
        int wr;
        int lvl;
        bit full;
        bit af;
        bit ovf;
    } mst_t;

    typedef struct {
        bit rst; bit winc; bit clr; int rd;
        int wen; int addr; int wptr; int full; int af; int lvl; int ovf;
    } vec_t;

    mst_t ms [3];
    int   rdc [3];
    int   depth_k [3] = '{8, 4, 64};
    int   af_k    [3] = '{6, 4, 62};
    int   pbits_k [3] = '{4, 3, 7};
    vec_t tv [$];

    int n_checks = 0;
    int n_errors = 0;
    int o_wen, o_addr, o_wptr, o_full, o_af, o_lvl, o_ovf;

    function automatic int gray(int v, int bits);
        int b;
        b = v & ((1 << bits) - 1);
        return b ^ (b >> 1);
    endfunction

    function automatic mst_t mstep(mst_t s, int depth, int af, bit rst, bit winc, int rd, bit clr);
        mst_t n;
        n = s;
        if (rst) begin
            n = '0;
        end else begin
            if (winc && !s.full) n.wr = s.wr + 1;
            n.lvl  = n.wr - rd;
            n.full = (n.lvl == depth);
            n.af   = (n.lvl >= af);
            if (winc && s.full) n.ovf = 1'b1;
            else if (clr)       n.ovf = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(bit rst, bit winc, bit clr, int rd,
                       int wen, int addr, int wptr, int full, int af, int lvl, int ovf);
        vec_t v;
        v.rst = rst; v.winc = winc; v.clr = clr; v.rd = rd;
        v.wen = wen; v.addr = addr; v.wptr = wptr; v.full = full;
        v.af = af; v.lvl = lvl; v.ovf = ovf;
        tv.push_back(v);
    endtask

    // One clock on instance k: drive at negedge, check w_en, then check registered outputs after the edge.
    task automatic cyc(int k, bit rst, bit winc, bit clr, int rd);
        @(negedge clk);
        rst0 = 1'b0; winc0 = 1'b0; clr0 = 1'b0;
        rst1 = 1'b0; winc1 = 1'b0; clr1 = 1'b0;
        rst2 = 1'b0; winc2 = 1'b0; clr2 = 1'b0;
        case (k)
            0: begin rst0 = rst; winc0 = winc; clr0 = clr; rptr0 = 4'(gray(rd, 4)); end
            1: begin rst1 = rst; winc1 = winc; clr1 = clr; rptr1 = 3'(gray(rd, 3)); end
            default: begin rst2 = rst; winc2 = winc; clr2 = clr; rptr2 = 7'(gray(rd, 7)); end
        endcase
        #1;
        case (k)
            0: o_wen = int'(wen0);
            1: o_wen = int'(wen1);
            default: o_wen = int'(wen2);
        endcase
        chk($sformatf("i%0d_w_en", k), o_wen, int'(winc && !ms[k].full));
        ms[k] = mstep(ms[k], depth_k[k], af_k[k], rst, winc, rd, clr);
        @(posedge clk);
        #1;
        case (k)
            0: begin o_addr = int'(addr0); o_wptr = int'(wptr0); o_full = int'(full0);
                     o_af = int'(af0); o_lvl = int'(lvl0); o_ovf = int'(ovf0); end
            1: begin o_addr = int'(addr1); o_wptr = int'(wptr1); o_full = int'(full1);
                     o_af = int'(af1); o_lvl = int'(lvl1); o_ovf = int'(ovf1); end
            default: begin o_addr = int'(addr2); o_wptr = int'(wptr2); o_full = int'(full2);
                     o_af = int'(af2); o_lvl = int'(lvl2); o_ovf = int'(ovf2); end
        endcase
        chk($sformatf("i%0d_w_addr", k), o_addr, ms[k].wr % depth_k[k]);
        chk($sformatf("i%0d_wptr", k), o_wptr, gray(ms[k].wr, pbits_k[k]));
        chk($sformatf("i%0d_w_full", k), o_full, int'(ms[k].full));
        chk($sformatf("i%0d_w_almost_full", k), o_af, int'(ms[k].af));
        chk($sformatf("i%0d_w_level", k), o_lvl, ms[k].lvl);
        chk($sformatf("i%0d_w_overflow", k), o_ovf, int'(ms[k].ovf));
    endtask

    task automatic rand_run(int k, int ncyc);
        bit phase, winc, clr, rst;
        for (int c = 0; c < ncyc; c++) begin
            phase = ((c / 300) % 2) == 0;
            winc  = $urandom_range(0, 99) < (phase ? 80 : 30);
            if (rdc[k] < ms[k].wr && $urandom_range(0, 99) < (phase ? 25 : 70)) rdc[k]++;
            clr   = $urandom_range(0, 19) == 0;
            rst   = $urandom_range(0, 499) == 0;
            cyc(k, rst, winc, clr, rdc[k]);
            if (rst) rdc[k] = 0;
        end
    endtask

    initial begin
        rst0 = 1'b1; winc0 = 1'b0; clr0 = 1'b0; rptr0 = '0;
        rst1 = 1'b1; winc1 = 1'b0; clr1 = 1'b0; rptr1 = '0;
        rst2 = 1'b1; winc2 = 1'b0; clr2 = 1'b0; rptr2 = '0;
        for (int i = 0; i < 3; i++) begin ms[i] = '0; rdc[i] = 0; end
        repeat (2) @(posedge clk);

        // rst winc clr rd | w_en addr wptr full af level ovf
        add(1,0,0,0,  0,0,0,0,0,0,0);
        add(1,0,0,0,  0,0,0,0,0,0,0);
        add(0,1,0,0,  1,1,1,0,0,1,0);
        add(0,1,0,0,  1,2,3,0,0,2,0);
        add(0,1,0,0,  1,3,2,0,0,3,0);
        add(0,1,0,0,  1,4,6,0,0,4,0);
        add(0,1,0,0,  1,5,7,0,0,5,0);
        add(0,1,0,0,  1,6,5,0,1,6,0);
        add(0,1,0,0,  1,7,4,0,1,7,0);
        add(0,1,0,0,  1,0,12,1,1,8,0);
        add(0,1,0,0,  0,0,12,1,1,8,1);
        add(0,1,0,0,  0,0,12,1,1,8,1);
        add(0,1,0,0,  0,0,12,1,1,8,1);
        add(0,0,0,0,  0,0,12,1,1,8,1);
        add(0,0,1,0,  0,0,12,1,1,8,0);
        add(0,1,1,0,  0,0,12,1,1,8,1);
        add(0,0,1,0,  0,0,12,1,1,8,0);
        add(0,0,0,1,  0,0,12,0,1,7,0);
        add(0,0,0,2,  0,0,12,0,1,6,0);
        add(0,0,0,3,  0,0,12,0,0,5,0);
        add(0,0,0,4,  0,0,12,0,0,4,0);
        add(0,0,0,5,  0,0,12,0,0,3,0);
        add(0,0,0,6,  0,0,12,0,0,2,0);
        add(0,0,0,7,  0,0,12,0,0,1,0);
        add(0,0,0,8,  0,0,12,0,0,0,0);
        add(0,1,0,8,  1,1,13,0,0,1,0);
        add(0,1,0,8,  1,2,15,0,0,2,0);
        add(0,1,0,8,  1,3,14,0,0,3,0);
        add(0,1,0,8,  1,4,10,0,0,4,0);
        add(0,1,0,8,  1,5,11,0,0,5,0);
        add(0,1,0,8,  1,6,9,0,1,6,0);
        add(0,1,0,8,  1,7,8,0,1,7,0);
        add(0,1,0,8,  1,0,0,1,1,8,0);
        add(0,0,0,9,  0,0,0,0,1,7,0);
        add(0,1,0,10, 1,1,1,0,1,7,0);
        add(0,0,0,11, 0,1,1,0,1,6,0);
        add(0,0,0,12, 0,1,1,0,0,5,0);
        add(1,1,0,12, 1,0,0,0,0,0,0);
        add(0,0,0,0,  0,0,0,0,0,0,0);

        foreach (tv[i]) begin
            cyc(0, tv[i].rst, tv[i].winc, tv[i].clr, tv[i].rd);
            chk($sformatf("tv%0d_w_en", i), o_wen, tv[i].wen);
            chk($sformatf("tv%0d_w_addr", i), o_addr, tv[i].addr);
            chk($sformatf("tv%0d_wptr", i), o_wptr, tv[i].wptr);
            chk($sformatf("tv%0d_w_full", i), o_full, tv[i].full);
            chk($sformatf("tv%0d_w_almost_full", i), o_af, tv[i].af);
            chk($sformatf("tv%0d_w_level", i), o_lvl, tv[i].lvl);
            chk($sformatf("tv%0d_w_overflow", i), o_ovf, tv[i].ovf);
        end
        rdc[0] = 0;
        rand_run(0, 3000);

        // Depth 4, threshold 4: full and almost-full rise together on the fourth write.
        cyc(1, 1'b1, 1'b0, 1'b0, 0);
        cyc(1, 1'b1, 1'b0, 1'b0, 0);
        chk("a2_reset_level", o_lvl, 0);
        chk("a2_reset_wptr", o_wptr, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1'b0, 1'b1, 1'b0, 0);
            chk($sformatf("a2_full_w%0d", i), o_full, (i == 4) ? 1 : 0);
            chk($sformatf("a2_af_w%0d", i), o_af, (i == 4) ? 1 : 0);
            chk($sformatf("a2_level_w%0d", i), o_lvl, i);
        end
        cyc(1, 1'b0, 1'b1, 1'b0, 0);
        chk("a2_ovf_set", o_ovf, 1);
        chk("a2_ovf_wptr_hold", o_wptr, 6);
        chk("a2_ovf_wen", o_wen, 0);
        rdc[1] = 0;
        rand_run(1, 2000);

        // Depth 64: fill to full, then random traffic.
        cyc(2, 1'b1, 1'b0, 1'b0, 0);
        cyc(2, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 64; i++) begin
            cyc(2, 1'b0, 1'b1, 1'b0, 0);
            if (i == 61) chk("a6_af_below", o_af, 0);
            if (i == 62) chk("a6_af_at", o_af, 1);
            if (i == 63) chk("a6_full_below", o_full, 0);
        end
        chk("a6_full", o_full, 1);
        chk("a6_level", o_lvl, 64);
        chk("a6_wptr_wrap", o_wptr, 96);
        rdc[2] = 0;
        rand_run(2, 4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_gen.md
Name: fifo_wptr_gen

Overview:
Parametrised write-side pointer and flag generator for the dual-clock asynchronous FIFO. It is the successor to the fixed depth-8 write-pointer block. It runs entirely in the write clock domain. It keeps a binary write counter and its registered Gray-coded image for crossing into the read domain. It derives full, almost-full, fill level and a sticky overflow flag from the read pointer, which arrives already synchronised (Gray-coded).

Parameters:
ADDR_SIZE, 3, FIFO address width; depth = 2^ADDR_SIZE; legal range 2..12.
PTR_SIZE, ADDR_SIZE+1, pointer width including the wrap bit; derived, must not be overridden.
AF_THRESH, 2^ADDR_SIZE-2, w_almost_full asserts when the fill level is >= AF_THRESH; legal range 1..2^ADDR_SIZE.

Ports:
w_clk  input  1  write-domain clock; all state updates on its rising edge.
wrst  input  1  synchronous active-high reset.
winc  input  1  write request from the producer.
wq2_rptr  input  PTR_SIZE  read pointer, Gray-coded, synchronised into w_clk.
w_ovf_clr  input  1  synchronous clear for w_overflow.
wptr  output  PTR_SIZE  registered Gray write pointer, sent to the read-domain synchroniser.
w_addr  output  ADDR_SIZE  registered binary write address into the dual-port RAM.
w_en  output  1  combinational RAM write enable = winc & ~w_full.
w_full  output  1  registered full flag.
w_almost_full  output  1  registered almost-full flag.
w_level  output  PTR_SIZE  registered fill level as seen from the write domain, 0..2^ADDR_SIZE.
w_overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (wrst=1 at a w_clk edge) forces all of the following to 0 on that edge: binary counter, wptr, w_addr, w_full, w_almost_full, w_level, w_overflow. Reset has priority over every other input.
- Reset mid-operation discards all pointer state. The read side must be reset in the same window; this block does no cross-domain recovery.
- Write acceptance: accepted = winc & ~w_full.
- Pointer update:
  - On an accepted write: wbin_next = wbin + 1, modulo 2^PTR_SIZE.
  - Otherwise wbin_next = wbin.
  - Registered updates: w_addr <= wbin_next[ADDR_SIZE-1:0]; wptr <= wbin_next ^ (wbin_next >> 1).
  - The write at the current w_addr happens on the same edge (zero latency). The pointer advances on that edge.
- Wrap: the counter rolls over from 2^PTR_SIZE-1 to 0 with no special handling. w_addr wraps every 2^ADDR_SIZE writes.
- Read pointer conversion: rbin is the combinational Gray-to-binary conversion of wq2_rptr:
  - rbin[MSB] = g[MSB];
  - rbin[i] = rbin[i+1] ^ g[i].
- Full (computed on the next pointer, no lookahead lag):
  - w_full <= (gray(wbin_next) == {~wq2_rptr[PTR_SIZE-1:PTR_SIZE-2], wq2_rptr[PTR_SIZE-3:0]}).
  - The check must handle ADDR_SIZE=2 correctly; the low-bit slice is 1 bit wide in that case.
- Level: w_level <= (wbin_next - rbin), modulo 2^PTR_SIZE. Range 0..2^ADDR_SIZE. It reads 2^ADDR_SIZE exactly when w_full is asserted.
- Almost-full: w_almost_full <= (wbin_next - rbin) >= AF_THRESH. It is always asserted whenever w_full is asserted.
- Pessimism: flags may stay asserted for up to 2–3 w_clk cycles after a read, because of synchroniser latency. This is correct behaviour. Flags never deassert early.
- Overflow:
  - Set: winc & w_full.
  - Clear: w_ovf_clr.
  - If set and clear occur together, set wins.
  - Otherwise w_overflow holds its value.
- Write while full: the pointer holds and the RAM is not written (w_en=0). Only w_overflow reacts.
- Simultaneous write and read-pointer change in one cycle: flags are computed from wbin_next and the current wq2_rptr. A freed slot becomes visible on the following edge.
- No state machine beyond the counter. All outputs except w_en are flops.

Test Plan:
Each test applies wrst for 2 cycles first and checks that every output is 0. Unless stated, ADDR_SIZE=3 and AF_THRESH=6.
- Fill: hold winc=1 with wq2_rptr=0 for 8 cycles.
  - w_addr steps 1..7 then 0.
  - wptr follows Gray 0001,0011,0010,0110,0111,0101,0100,1100.
  - w_almost_full rises after write 6; w_full rises after write 8.
  - w_level reads 8.
- Overflow: from full, pulse winc for 3 cycles.
  - wptr stays 1100; w_en=0 throughout.
  - w_overflow=1 and stays 1 after winc drops.
  - w_ovf_clr=1 for one cycle clears it; clr and winc together while full leaves it at 1.
- Drain and wrap: from full, drive wq2_rptr through Gray 1..8 (1100) over 8 cycles with winc=0.
  - w_full falls the cycle after wq2_rptr=0001.
  - w_level ends at 0.
  - 8 further writes wrap wptr to 0000 and re-assert full against rptr 1100.
- Simultaneous events: at level 7, assert winc on the same edge wq2_rptr advances by one. Next cycle w_level=7, w_full=0.
- Reset mid-operation: assert wrst at level 5 with winc=1. Next cycle all outputs are 0, and the write in that cycle is dropped.
- Parameter sweep, ADDR_SIZE=2, AF_THRESH=4: w_full and w_almost_full assert on the same edge after 4 writes. Also regress with ADDR_SIZE=6.
